// File: rtl/fsm_tick_pkg.sv
// Shared definitions for the tick-driven counting controller:
// state encoding and the divider width helper.
package fsm_tick_pkg;

    // State encoding; PAUSE is only reachable when the pause feature is built in.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Bits needed to count 0..tick_div-1 (never less than one bit).
    function automatic int div_width(input int tick_div);
        return (tick_div > 2) ? $clog2(tick_div) : 1;
    endfunction

endpackage

// File: rtl/fsm_tick_counter_tick_gen.sv
// Tick divider: counts 0..TICK_DIV-1 and emits a registered one-cycle
// strobe on the wrap. `clear` restarts it from 0, `hold` freezes it.
module tick_gen
    import fsm_tick_pkg::*;
#(
    parameter int TICK_DIV = 1500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int             DW   = div_width(TICK_DIV);
    localparam logic [DW-1:0]  LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0]  ONE  = DW'(1);

    logic [DW-1:0] div_reg;

    // Divider count and tick strobe; clear wins over hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg <= '0;
            tick    <= 1'b0;
        end else if (clear) begin
            div_reg <= '0;
            tick    <= 1'b0;
        end else if (hold) begin
            tick    <= 1'b0;
        end else if (div_reg == LAST) begin
            div_reg <= '0;
            tick    <= 1'b1;
        end else begin
            div_reg <= div_reg + ONE;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/fsm_tick_counter.sv
// Moore counting controller: `go` starts a count up to (or down from) a
// latched limit, one step per divider tick, then holds DONE for DONE_TICKS
// ticks before returning to IDLE. `abort` returns to IDLE from any busy state.
// Optional pause support is compiled in with FSM_TICK_COUNTER_PAUSE_EN:
// `go` then toggles between COUNT and PAUSE, freezing count and divider.
module fsm_tick_counter
    import fsm_tick_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int TICK_DIV   = 1500000,
    parameter int DONE_TICKS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic             dir_down,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tick
);

    localparam int               DCW       = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
    localparam logic [DCW-1:0]   DONE_LAST = DCW'(DONE_TICKS - 1);
    localparam logic [DCW-1:0]   DONE_ONE  = DCW'(1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] limit_reg, limit_next;
    logic             dir_reg, dir_next;
    logic [DCW-1:0]   done_cnt_reg, done_cnt_next;
    logic [WIDTH-1:0] target;
    logic             div_clear;
    logic             div_hold;
    logic             tick_w;

    // Terminal value: the latched limit when counting up, zero when counting down.
    assign target = dir_reg ? '0 : limit_reg;

    // Divider freezes for exactly the cycles spent in PAUSE.
    assign div_hold = (state_next == ST_PAUSE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .hold  (div_hold),
        .tick  (tick_w)
    );

    // State, count, latched operands and done-tick counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            limit_reg    <= '0;
            dir_reg      <= 1'b0;
            done_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            limit_reg    <= limit_next;
            dir_reg      <= dir_next;
            done_cnt_reg <= done_cnt_next;
        end
    end

    // Next-state logic; priority is abort, then tick, then go.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        limit_next    = limit_reg;
        dir_next      = dir_reg;
        done_cnt_next = done_cnt_reg;
        div_clear     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                count_next = '0;
                if (go) begin
                    limit_next = limit;
                    dir_next   = dir_down;
                    count_next = dir_down ? limit : '0;
                    div_clear  = 1'b1;
                    state_next = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (tick_w) begin
                    // Terminal check precedes the step, so the count never wraps.
                    if (count_reg == target) begin
                        state_next    = ST_DONE;
                        done_cnt_next = '0;
                    end else begin
                        count_next = dir_reg ? (count_reg - ONE) : (count_reg + ONE);
                    end
                end
`ifdef FSM_TICK_COUNTER_PAUSE_EN
                else if (go) begin
                    state_next = ST_PAUSE;
                end
`endif
            end
            ST_DONE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (tick_w) begin
                    if (done_cnt_reg == DONE_LAST) begin
                        state_next = ST_IDLE;
                        count_next = '0;
                    end else begin
                        done_cnt_next = done_cnt_reg + DONE_ONE;
                    end
                end
            end
`ifdef FSM_TICK_COUNTER_PAUSE_EN
            ST_PAUSE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (go) begin
                    state_next = ST_COUNT;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    assign count = count_reg;
`ifdef FSM_TICK_COUNTER_PAUSE_EN
    assign busy  = (state_reg == ST_COUNT) || (state_reg == ST_PAUSE);
`else
    assign busy  = (state_reg == ST_COUNT);
`endif
    assign done  = (state_reg == ST_DONE);
    assign tick  = tick_w;

endmodule

// File: tb/tb_fsm_tick_counter.sv
// Self-checking bench for fsm_tick_counter (WIDTH=4, TICK_DIV=4, DONE_TICKS=2).
// A cycle-level model fills a queue of expected {count,busy,done,tick} per
// cycle when a start is driven; each scenario pops and compares as it runs.
module tb_fsm_tick_counter;
    import fsm_tick_pkg::*;

    localparam int WIDTH      = 4;
    localparam int TICK_DIV   = 4;
    localparam int DONE_TICKS = 2;

    logic             clk      = 1'b0;
    logic             rst      = 1'b0;
    logic             go       = 1'b0;
    logic             abort    = 1'b0;
    logic             dir_down = 1'b0;
    logic [WIDTH-1:0] limit    = '0;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tick;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             done;
        logic             tick;
    } exp_t;

    exp_t exp_q[$];

    fsm_tick_counter #(
        .WIDTH      (WIDTH),
        .TICK_DIV   (TICK_DIV),
        .DONE_TICKS (DONE_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .abort    (abort),
        .dir_down (dir_down),
        .limit    (limit),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // Advance one clock; observe 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start pulse with the given operands.
    task automatic start(input logic [WIDTH-1:0] lim, input logic down);
        limit    = lim;
        dir_down = down;
        go       = 1'b1;
        step();
        go       = 1'b0;
    endtask

    // Expected per-cycle outputs, starting with the observation right after
    // the edge that samples go (t=0) and ending with the first IDLE cycle.
    function automatic void build_expected(input logic [WIDTH-1:0] lim, input logic down);
        int   t;
        int   dur;
        exp_t e;
        t = 0;
        for (int j = 0; j <= int'(lim); j++) begin
            dur = (j == 0) ? TICK_DIV + 1 : TICK_DIV;
            for (int k = 0; k < dur; k++) begin
                e.cnt  = down ? WIDTH'(int'(lim) - j) : WIDTH'(j);
                e.busy = 1'b1;
                e.done = 1'b0;
                e.tick = (t > 0) && (t % TICK_DIV == 0);
                exp_q.push_back(e);
                t++;
            end
        end
        for (int k = 0; k < DONE_TICKS * TICK_DIV; k++) begin
            e.cnt  = down ? '0 : lim;
            e.busy = 1'b0;
            e.done = 1'b1;
            e.tick = (t % TICK_DIV == 0);
            exp_q.push_back(e);
            t++;
        end
        e.cnt  = '0;
        e.busy = 1'b0;
        e.done = 1'b0;
        e.tick = (t % TICK_DIV == 0);
        exp_q.push_back(e);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({count, busy, done, tick} !== {WIDTH'(0), 3'b000}) begin
            n_err++;
            $display("FAIL reset_assert: got cnt=%0d busy=%b done=%b tick=%b, expected all 0", count, busy, done, tick);
        end
        step();
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if ({count, busy, done, tick} !== {WIDTH'(0), 3'b000}) begin
            n_err++;
            $display("FAIL reset_release: got cnt=%0d busy=%b done=%b tick=%b, expected all 0", count, busy, done, tick);
        end
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_sequences();
        logic [WIDTH-1:0] lims [5];
        logic             dirs [5];
        exp_t             e;
        int               t;
        lims = '{4'd3, 4'd2, 4'd0, 4'd15, 4'd0};
        dirs = '{1'b0, 1'b1, 1'b0, 1'b0,  1'b1};
        for (int s = 0; s < 5; s++) begin
            build_expected(lims[s], dirs[s]);
            start(lims[s], dirs[s]);
            t = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({count, busy, done, tick} !== {e.cnt, e.busy, e.done, e.tick}) begin
                    n_err++;
                    $display("FAIL seq limit=%0d down=%0b t=%0d: got cnt=%0d busy=%b done=%b tick=%b, expected cnt=%0d busy=%b done=%b tick=%b",
                             lims[s], dirs[s], t, count, busy, done, tick, e.cnt, e.busy, e.done, e.tick);
                end
                t++;
                step();
            end
            $display("sequence: limit=%0d down=%0b checked %0d cycles", lims[s], dirs[s], t);
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        build_expected(4'd9, 1'b0);
        start(4'd9, 1'b0);
        for (int t = 0; t <= 21; t++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({count, busy, done, tick} !== {e.cnt, e.busy, e.done, e.tick}) begin
                n_err++;
                $display("FAIL reset_mid_pre t=%0d: got cnt=%0d busy=%b done=%b tick=%b, expected cnt=%0d busy=%b done=%b tick=%b",
                         t, count, busy, done, tick, e.cnt, e.busy, e.done, e.tick);
            end
            if (t < 21) step();
        end
        exp_q.delete();
        // count is 5 here; reset must clear everything without waiting for a clock edge.
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({count, busy, done, tick, (dut.state_reg == ST_IDLE)} !== {WIDTH'(0), 3'b000, 1'b1}) begin
            n_err++;
            $display("FAIL reset_mid: got cnt=%0d busy=%b done=%b tick=%b state=%0d, expected all 0 and IDLE",
                     count, busy, done, tick, dut.state_reg);
        end
        step();
        rst = 1'b0;
        step();
        $display("reset_mid: asynchronous reset at count 5");
    endtask

    task automatic test_abort();
        exp_t e;
        build_expected(4'd5, 1'b0);
        start(4'd5, 1'b0);
        for (int t = 0; t <= 9; t++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({count, busy, done, tick} !== {e.cnt, e.busy, e.done, e.tick}) begin
                n_err++;
                $display("FAIL abort_pre t=%0d: got cnt=%0d busy=%b done=%b tick=%b, expected cnt=%0d busy=%b done=%b tick=%b",
                         t, count, busy, done, tick, e.cnt, e.busy, e.done, e.tick);
            end
            abort = (t == 9);
            step();
        end
        abort = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if ({count, busy, done} !== {WIDTH'(0), 2'b00}) begin
                n_err++;
                $display("FAIL abort_post k=%0d: got cnt=%0d busy=%b done=%b, expected cnt=0 busy=0 done=0", k, count, busy, done);
            end
            step();
        end
        $display("abort: abort at count 2 returned to idle");
    endtask

    task automatic test_abort_at_terminal();
        exp_t e;
        build_expected(4'd2, 1'b0);
        start(4'd2, 1'b0);
        for (int t = 0; t <= 12; t++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({count, busy, done, tick} !== {e.cnt, e.busy, e.done, e.tick}) begin
                n_err++;
                $display("FAIL abort_term_pre t=%0d: got cnt=%0d busy=%b done=%b tick=%b, expected cnt=%0d busy=%b done=%b tick=%b",
                         t, count, busy, done, tick, e.cnt, e.busy, e.done, e.tick);
            end
            abort = (t == 12);
            step();
        end
        abort = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if ({count, busy, done} !== {WIDTH'(0), 2'b00}) begin
                n_err++;
                $display("FAIL abort_term_post k=%0d: got cnt=%0d busy=%b done=%b, expected cnt=0 busy=0 done=0", k, count, busy, done);
            end
            step();
        end
        $display("abort_terminal: abort beat the terminal tick");
    endtask

`ifdef FSM_TICK_COUNTER_PAUSE_EN
    task automatic test_pause();
        exp_t e;
        int   t;
        build_expected(4'd3, 1'b0);
        e.cnt  = 4'd1;
        e.busy = 1'b1;
        e.done = 1'b0;
        e.tick = 1'b0;
        for (int k = 0; k < 20; k++) exp_q.insert(6, e);
        start(4'd3, 1'b0);
        t = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({count, busy, done, tick} !== {e.cnt, e.busy, e.done, e.tick}) begin
                n_err++;
                $display("FAIL pause t=%0d: got cnt=%0d busy=%b done=%b tick=%b, expected cnt=%0d busy=%b done=%b tick=%b",
                         t, count, busy, done, tick, e.cnt, e.busy, e.done, e.tick);
            end
            go = (t == 5) || (t == 25);
            t++;
            step();
        end
        go = 1'b0;
        $display("pause: 20-cycle pause at count 1 checked over %0d cycles", t);
    endtask
`else
    task automatic test_go_in_count();
        exp_t e;
        int   t;
        build_expected(4'd3, 1'b0);
        start(4'd3, 1'b0);
        t = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({count, busy, done, tick} !== {e.cnt, e.busy, e.done, e.tick}) begin
                n_err++;
                $display("FAIL go_in_count t=%0d: got cnt=%0d busy=%b done=%b tick=%b, expected cnt=%0d busy=%b done=%b tick=%b",
                         t, count, busy, done, tick, e.cnt, e.busy, e.done, e.tick);
            end
            go       = (t == 6);
            limit    = (t == 6) ? 4'd7 : 4'd3;
            dir_down = (t == 6);
            t++;
            step();
        end
        go       = 1'b0;
        dir_down = 1'b0;
        $display("go_in_count: stray go during COUNT ignored over %0d cycles", t);
    endtask
`endif

    initial begin
        test_reset();
        test_sequences();
        test_reset_mid_count();
        test_abort();
        test_abort_at_terminal();
`ifdef FSM_TICK_COUNTER_PAUSE_EN
        test_pause();
`else
        test_go_in_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
